decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Registered, parametrised instruction decode stage with a DEPTH-entry output queue, sitting between fetch and register-read/execute.
- Generalises the combinational RV32I field decoder in three ways:
  - XLEN-wide immediates and PC, with RV64I opcodes when XLEN=64.
  - Instruction-format classification with illegal-instruction detection.
  - valid/ready handshakes on both sides, plus a flush for branch/jump redirects.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets immediate sign-extension width and RV64-only legality.
- DEPTH, 2, number of decoded-entry queue slots; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries and any same-cycle input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_opcode  out  7  instr[6:0].
- out_rd_addr / out_rs1_addr / out_rs2_addr  out  5 each  register addresses; 0 when the field is unused by the format.
- out_funct3  out  3  0 when unused.
- out_funct7  out  7  0 when unused.
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
- out_fmt  out  3  instr_fmt_t: R, I, S, B, U, J, ILLEGAL.
- out_rd_we  out  1  format writes rd and rd!=0.
- out_illegal  out  1  instruction failed legality checks.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- **Decode (combinational on the input side).**
  - Field extraction and immediates per RV32I formats: I, S, B, J, U; U is instr[31:12]<<12.
  - All immediates are sign-extended from instr[31] to XLEN.
  - The decoded record is written into the queue; nothing else is registered.
- **Legality.** out_illegal=1 and fmt=ILLEGAL when any of:
  - Opcode is not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}; when XLEN=64, OP-IMM-32 and OP-32 are also legal.
  - OP: funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101}.
  - OP-IMM shifts:
    - XLEN=32: funct3=001 requires instr[31:25]=0; funct3=101 requires instr[31:25] in {0000000, 0100000}.
    - XLEN=64: the check covers instr[31:26] only.
  - JALR with funct3!=000.
  - BRANCH with funct3 in {010, 011}.
  - LOAD with funct3 = 111; also 011 or 110 when XLEN=32.
  - STORE with funct3 > 010 when XLEN=32, or > 011 when XLEN=64.
- **Illegal entries** are still queued in program order with their PC. Register addresses, funct fields and imm are forced to 0, and rd_we=0.
- **Handshakes.**
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH), registered-state based only; there is no combinational path from out_ready to in_ready.
  - Push and pop in the same cycle are allowed at any occupancy below DEPTH; count is unchanged.
  - When full, a pop does not enable a same-cycle push.
- **Latency.**
  - An instruction pushed in cycle N is visible on out_* in cycle N+1 when the queue was empty.
  - Otherwise it appears behind older entries (FIFO order).
- **Outputs** are driven directly from the head entry register. While out_valid=1 and out_ready=0 the head entry is held stable.
- **Queue pointers.**
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count separately distinguishes full from empty.
- **Flush.**
  - Next cycle: count=0 and out_valid=0.
  - Any push or pop in the flush cycle is ignored.
  - in_ready is 1 the cycle after a flush.
- **Reset.**
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - All out_* data fields read 0, because entry storage is cleared on reset.
  - Reset mid-stream discards the contents exactly like a flush.
  - rst has priority over flush.

Decomposition:
- Shared package (alongside the existing opcode constants) gains:
  - instr_fmt_t enum (3-bit).
  - decoded_instr_t packed struct parametrised on XLEN through a typedef in the module.
  - OP_IMM_32 and OP_32 opcode constants.
  - funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
- One sub-module: decode_comb, purely combinational, mapping instr to decoded_instr_t including the legality checks. decode_queue instantiates it and owns the queue storage and handshake logic.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), XLEN=32, queue empty, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, fmt=I, rd_we=1, illegal=0.
- BEQ with imm=-4 (0xFE000EE3), XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFC, fmt=B, rd=0, rd_we=0.
- Push 0x00000000, then OP with funct7=0100000/funct3=001 -> both entries in order with illegal=1, fmt=ILLEGAL, imm=0, rd_we=0.
- DEPTH=2, out_ready=0, push 3 instructions -> in_ready=0 after 2 pushes, count=2, head stable; then out_ready=1 -> instructions drain in order, and the third is accepted the cycle after in_ready rises.
- count=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, and no entry from that cycle appears later.
- Assert rst while count=1, continuous push/pop streaming across 3×DEPTH entries (pointer wrap) -> after reset out_valid=0, count=0; the post-reset stream emerges in exact order with correct PCs.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: opcodes, funct7 values,
// instruction format enum and decoded-record width helper.
package decode_queue_pkg;

  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILLEGAL
  } instr_fmt_t;

  // Bits in a decoded record: opcode, 3 regs, funct3/7,
  // fmt, rd_we, illegal plus an XLEN-wide immediate.
  function automatic int dec_width(input int xlen);
    return xlen + 7 + 15 + 3 + 7 + 3 + 2;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I field decoder with
// format classification and legality checking.
module decode_comb
  import decode_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]                  instr,
  output logic [dec_width(XLEN)-1:0]   dec
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    instr_fmt_t      fmt;
    logic            rd_we;
    logic            illegal;
  } decoded_instr_t;

  decoded_instr_t d;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0}));

  instr_fmt_t fmt;
  logic       bad;
  logic       shift_bad;

  // Shift-immediate encodings: RV64 frees bit 25 for shamt[5]
  always_comb begin
    shift_bad = 1'b0;
    if (XLEN == 64) begin
      if (f3 == 3'b001)
        shift_bad = instr[31:26] != 6'b000000;
      else if (f3 == 3'b101)
        shift_bad = (instr[31:26] != 6'b000000) &&
                    (instr[31:26] != 6'b010000);
    end else begin
      if (f3 == 3'b001)
        shift_bad = f7 != F7_BASE;
      else if (f3 == 3'b101)
        shift_bad = (f7 != F7_BASE) && (f7 != F7_ALT);
    end
  end

  // Classify opcode into a format and flag bad encodings
  always_comb begin
    fmt = FMT_ILLEGAL;
    bad = 1'b0;
    unique case (1'b1)
      (opc == LUI), (opc == AUIPC): fmt = FMT_U;
      (opc == JAL): fmt = FMT_J;
      (opc == JALR): begin
        fmt = FMT_I;
        bad = f3 != 3'b000;
      end
      (opc == BRANCH): begin
        fmt = FMT_B;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      (opc == LOAD): begin
        fmt = FMT_I;
        bad = (f3 == 3'b111) ||
              ((XLEN == 32) &&
               ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      (opc == STORE): begin
        fmt = FMT_S;
        bad = f3 > ((XLEN == 32) ? 3'd2 : 3'd3);
      end
      (opc == OP_IMM): begin
        fmt = FMT_I;
        bad = shift_bad;
      end
      (opc == OP): begin
        fmt = FMT_R;
        bad = !((f7 == F7_BASE) ||
                ((f7 == F7_ALT) &&
                 ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      ((XLEN == 64) && (opc == OP_IMM_32)): fmt = FMT_I;
      ((XLEN == 64) && (opc == OP_32)): fmt = FMT_R;
      default: bad = 1'b1;
    endcase
  end

  // Populate only the fields the format uses
  always_comb begin
    d        = '0;
    d.opcode = opc;
    if (bad) begin
      d.fmt     = FMT_ILLEGAL;
      d.illegal = 1'b1;
    end else begin
      d.fmt = fmt;
      case (fmt)
        FMT_R: begin
          d.rd     = instr[11:7];
          d.rs1    = instr[19:15];
          d.rs2    = instr[24:20];
          d.funct3 = f3;
          d.funct7 = f7;
        end
        FMT_I: begin
          d.rd     = instr[11:7];
          d.rs1    = instr[19:15];
          d.funct3 = f3;
          d.imm    = imm_i;
        end
        FMT_S: begin
          d.rs1    = instr[19:15];
          d.rs2    = instr[24:20];
          d.funct3 = f3;
          d.imm    = imm_s;
        end
        FMT_B: begin
          d.rs1    = instr[19:15];
          d.rs2    = instr[24:20];
          d.funct3 = f3;
          d.imm    = imm_b;
        end
        FMT_U: begin
          d.rd  = instr[11:7];
          d.imm = imm_u;
        end
        FMT_J: begin
          d.rd  = instr[11:7];
          d.imm = imm_j;
        end
        default: d.illegal = 1'b1;
      endcase
      d.rd_we = (fmt != FMT_S) && (fmt != FMT_B) &&
                (d.rd != 5'd0);
    end
  end

  assign dec = d;

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes fetched instructions
// into a DEPTH-entry FIFO with valid/ready and flush.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd_addr,
  output logic [4:0]                 out_rs1_addr,
  output logic [4:0]                 out_rs2_addr,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [XLEN-1:0]            out_imm,
  output instr_fmt_t                 out_fmt,
  output logic                       out_rd_we,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    instr_fmt_t      fmt;
    logic            rd_we;
    logic            illegal;
  } decoded_instr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    decoded_instr_t  dec;
  } entry_t;

  decoded_instr_t dec_in;
  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW-1:0]  rptr;
  logic [AW-1:0]  wptr;
  logic [CW-1:0]  cnt;
  logic           push;
  logic           pop;

  decode_comb #(
    .XLEN (XLEN)
  ) u_dec (
    .instr (in_instr),
    .dec   (dec_in)
  );

  assign in_ready  = cnt != CW'(DEPTH);
  assign out_valid = cnt != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // FIFO state; reset clears storage, flush only empties
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{pc: in_pc, dec: dec_in};
        wptr      <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head         = mem[rptr];
  assign out_pc       = head.pc;
  assign out_opcode   = head.dec.opcode;
  assign out_rd_addr  = head.dec.rd;
  assign out_rs1_addr = head.dec.rs1;
  assign out_rs2_addr = head.dec.rs2;
  assign out_funct3   = head.dec.funct3;
  assign out_funct7   = head.dec.funct7;
  assign out_imm      = head.dec.imm;
  assign out_fmt      = head.dec.fmt;
  assign out_rd_we    = head.dec.rd_we;
  assign out_illegal  = head.dec.illegal;
  assign count        = cnt;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vector table
// on XLEN=32/64 plus backpressure, flush and reset runs.
module tb_decode_queue;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_instr, a_pc, a_out_pc, a_imm;
  logic [6:0]  a_opc, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3, a_fmt;
  logic        a_we, a_ill;
  logic [1:0]  a_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_instr;
  logic [63:0] b_pc, b_out_pc, b_imm;
  logic [6:0]  b_opc, b_f7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3, b_fmt;
  logic        b_we, b_ill;
  logic [1:0]  b_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_instr), .in_pc(a_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_opcode(a_opc),
    .out_rd_addr(a_rd), .out_rs1_addr(a_rs1),
    .out_rs2_addr(a_rs2), .out_funct3(a_f3),
    .out_funct7(a_f7), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_rd_we(a_we), .out_illegal(a_ill), .count(a_count)
  );

  decode_queue #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_instr), .in_pc(b_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_opcode(b_opc),
    .out_rd_addr(b_rd), .out_rs1_addr(b_rs1),
    .out_rs2_addr(b_rs2), .out_funct3(b_f3),
    .out_funct7(b_f7), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_rd_we(b_we), .out_illegal(b_ill), .count(b_count)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        we, ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } vec64_t;

  localparam logic [2:0] R = 0, I = 1, S = 2, B = 3;
  localparam logic [2:0] U = 4, J = 5, X = 6;

  vec_t   vt [19];
  vec64_t wt [6];

  function automatic vec_t mk(
    logic [31:0] instr, logic [2:0] fmt, logic [4:0] rd,
    logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
    logic [6:0] f7, logic [31:0] imm, logic we, logic ill);
    vec_t v;
    v.instr = instr; v.fmt = fmt; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.we = we; v.ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] addi(input int k);
    logic [11:0] im;
    logic [4:0]  rd;
    im = 12'(k);
    rd = 5'(k + 1);
    return {im, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv;
    logic [31:0] hold_imm;

    vt[0]  = mk(32'hFFF00093, I, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0);
    vt[1]  = mk(32'h002081B3, R, 3, 1, 2, 0, 0, 32'h0, 1, 0);
    vt[2]  = mk(32'h402081B3, R, 3, 1, 2, 0, 7'h20, 32'h0, 1, 0);
    vt[3]  = mk(32'h123452B7, U, 5, 0, 0, 0, 0, 32'h12345000, 1, 0);
    vt[4]  = mk(32'h0020A423, S, 0, 1, 2, 2, 0, 32'h8, 0, 0);
    vt[5]  = mk(32'hFE000EE3, B, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0);
    vt[6]  = mk(32'h008000EF, J, 1, 0, 0, 0, 0, 32'h8, 1, 0);
    vt[7]  = mk(32'h8000006F, J, 0, 0, 0, 0, 0, 32'hFFF00000, 0, 0);
    vt[8]  = mk(32'h4020D093, I, 1, 1, 0, 5, 0, 32'h402, 1, 0);
    vt[9]  = mk(32'hFFFFF117, U, 2, 0, 0, 0, 0, 32'hFFFFF000, 1, 0);
    vt[10] = mk(32'h00000000, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[11] = mk(32'h402091B3, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[12] = mk(32'h000090E7, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[13] = mk(32'h00003083, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[14] = mk(32'h02309093, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[15] = mk(32'h0000001B, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[16] = mk(32'h00002063, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[17] = mk(32'h00003023, X, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[18] = mk(32'h020081B3, X, 0, 0, 0, 0, 0, 0, 0, 1);

    wt[0] = '{32'hFE000EE3, B, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    wt[1] = '{32'h00003083, I, 64'h0, 1'b0};
    wt[2] = '{32'h02309093, I, 64'd35, 1'b0};
    wt[3] = '{32'h0010809B, I, 64'd1, 1'b0};
    wt[4] = '{32'h00003023, S, 64'h0, 1'b0};
    wt[5] = '{32'h00007003, X, 64'h0, 1'b1};

    rst = 1; flush = 0;
    a_in_valid = 0; a_instr = 0; a_pc = 0; a_out_ready = 1;
    b_in_valid = 0; b_instr = 0; b_pc = 0; b_out_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    check("rst.count", 64'(a_count), 0);
    check("rst.out_valid", 64'(a_out_valid), 0);
    check("rst.in_ready", 64'(a_in_ready), 1);
    check("rst.out_pc", 64'(a_out_pc), 0);
    check("rst.out_imm", 64'(a_imm), 0);
    check("rst64.out_imm", b_imm, 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      a_in_valid = 1;
      a_instr = vt[i].instr;
      a_pc = 32'h100 + 32'(4 * i);
      @(posedge clk);
      #1;
      a_in_valid = 0;
      check($sformatf("v%0d.valid", i), 64'(a_out_valid), 1);
      check($sformatf("v%0d.pc", i), 64'(a_out_pc),
            64'(32'h100 + 32'(4 * i)));
      check($sformatf("v%0d.opc", i), 64'(a_opc),
            64'(vt[i].instr[6:0]));
      check($sformatf("v%0d.fmt", i), 64'(a_fmt), 64'(vt[i].fmt));
      check($sformatf("v%0d.rd", i), 64'(a_rd), 64'(vt[i].rd));
      check($sformatf("v%0d.rs1", i), 64'(a_rs1), 64'(vt[i].rs1));
      check($sformatf("v%0d.rs2", i), 64'(a_rs2), 64'(vt[i].rs2));
      check($sformatf("v%0d.f3", i), 64'(a_f3), 64'(vt[i].f3));
      check($sformatf("v%0d.f7", i), 64'(a_f7), 64'(vt[i].f7));
      check($sformatf("v%0d.imm", i), 64'(a_imm), 64'(vt[i].imm));
      check($sformatf("v%0d.we", i), 64'(a_we), 64'(vt[i].we));
      check($sformatf("v%0d.ill", i), 64'(a_ill), 64'(vt[i].ill));
    end

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_in_valid = 1;
      b_instr = wt[i].instr;
      b_pc = 64'hFFFF_0000_0000_0000 + 64'(8 * i);
      @(posedge clk);
      #1;
      b_in_valid = 0;
      check($sformatf("w%0d.pc", i), b_out_pc,
            64'hFFFF_0000_0000_0000 + 64'(8 * i));
      check($sformatf("w%0d.fmt", i), 64'(b_fmt), 64'(wt[i].fmt));
      check($sformatf("w%0d.imm", i), b_imm, wt[i].imm);
      check($sformatf("w%0d.ill", i), 64'(b_ill), 64'(wt[i].ill));
    end
    check("w0.rd_we", 64'(b_we), 0);

    // drain, then backpressure with three pushes
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 1; b_in_valid = 0;
    @(negedge clk);
    check("bp.empty", 64'(a_count), 0);
    a_out_ready = 0;
    a_in_valid = 1; a_instr = 32'h00100093; a_pc = 32'h1000;
    @(negedge clk);
    a_instr = 32'h00200113; a_pc = 32'h1004;
    @(negedge clk);
    a_instr = 32'h00300193; a_pc = 32'h1008;
    @(negedge clk);
    check("bp.count_full", 64'(a_count), 2);
    check("bp.in_ready_full", 64'(a_in_ready), 0);
    check("bp.head_pc", 64'(a_out_pc), 32'h1000);
    hold_imm = a_imm;
    @(negedge clk);
    check("bp.head_stable_pc", 64'(a_out_pc), 32'h1000);
    check("bp.head_stable_imm", 64'(a_imm), 64'(hold_imm));
    check("bp.head_rd", 64'(a_rd), 1);
    a_out_ready = 1;
    @(negedge clk);
    check("bp.pop1_count", 64'(a_count), 1);
    check("bp.pop1_pc", 64'(a_out_pc), 32'h1004);
    check("bp.pop1_in_ready", 64'(a_in_ready), 1);
    @(negedge clk);
    a_in_valid = 0;
    check("bp.pop2_count", 64'(a_count), 1);
    check("bp.pop2_pc", 64'(a_out_pc), 32'h1008);
    check("bp.pop2_rd", 64'(a_rd), 3);
    @(negedge clk);
    check("bp.drained", 64'(a_out_valid), 0);

    // flush while full with concurrent push and pop
    a_out_ready = 0;
    a_in_valid = 1; a_instr = 32'h00100093; a_pc = 32'h3000;
    @(negedge clk);
    a_pc = 32'h3004;
    @(negedge clk);
    check("fl.count_pre", 64'(a_count), 2);
    flush = 1; a_out_ready = 1; a_pc = 32'h3008;
    @(negedge clk);
    flush = 0; a_in_valid = 0;
    check("fl.count", 64'(a_count), 0);
    check("fl.out_valid", 64'(a_out_valid), 0);
    check("fl.in_ready", 64'(a_in_ready), 1);
    repeat (2) @(negedge clk);
    check("fl.stays_empty", 64'(a_out_valid), 0);
    a_in_valid = 1; a_pc = 32'h300C;
    @(negedge clk);
    a_in_valid = 0;
    check("fl.next_pc", 64'(a_out_pc), 32'h300C);
    check("fl.next_count", 64'(a_count), 1);
    @(negedge clk);

    // reset mid-stream, with flush also asserted
    a_out_ready = 0;
    a_in_valid = 1; a_pc = 32'h4000;
    @(negedge clk);
    a_in_valid = 0;
    check("rs.count_pre", 64'(a_count), 1);
    rst = 1; flush = 1; a_in_valid = 1; a_pc = 32'h4004;
    @(negedge clk);
    rst = 0; flush = 0; a_in_valid = 0;
    check("rs.count", 64'(a_count), 0);
    check("rs.out_valid", 64'(a_out_valid), 0);
    check("rs.out_pc", 64'(a_out_pc), 0);
    check("rs.in_ready", 64'(a_in_ready), 1);

    // streaming push/pop across the pointer wrap
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      @(negedge clk);
      a_in_valid = sent < 6;
      a_instr = addi(sent);
      a_pc = 32'h2000 + 32'(4 * sent);
      a_out_ready = (cyc % 3) != 2;
      #1;
      if (a_out_valid && a_out_ready) begin
        check($sformatf("st%0d.pc", recv), 64'(a_out_pc),
              64'(32'h2000 + 32'(4 * recv)));
        check($sformatf("st%0d.rd", recv), 64'(a_rd),
              64'(recv + 1));
        check($sformatf("st%0d.imm", recv), 64'(a_imm),
              64'(recv));
        recv++;
      end
      if (a_in_valid && a_in_ready) sent++;
    end
    a_in_valid = 0;
    check("st.received", 64'(recv), 6);
    @(negedge clk);
    check("st.empty", 64'(a_count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
